// File: rtl/parity_frame_rx_if.sv
// Serial-line / received-word bundle for parity_frame_rx.
//   din, din_valid            : serial bit and its strobe (toward receiver)
//   dout, dout_valid          : received word and one-cycle strobe
//   par_err, frm_err          : per-frame error flags, qualified by dout_valid
//   busy                      : receiver is inside a frame
// master = line driver / consumer, slave = receiver.
interface parity_frame_rx_if #(
  parameter int unsigned DATA_W = 8
);
  logic              din;
  logic              din_valid;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              par_err;
  logic              frm_err;
  logic              busy;

  modport master (
    output din, din_valid,
    input  dout, dout_valid, par_err, frm_err, busy
  );

  modport slave (
    input  din, din_valid,
    output dout, dout_valid, par_err, frm_err, busy
  );
endinterface

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: strobed serial frame receiver.
// Frame on the line: start(0), DATA_W data bits LSB first, parity bit, stop(1).
// din is only looked at when din_valid=1; din_valid=0 stalls everything.
// Ports:
//   clk  : single rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : parity_frame_rx_if.slave (din/din_valid in; dout, dout_valid,
//          par_err, frm_err, busy out)
// Build option: define PARITY_ODD_EN for odd parity; even parity otherwise.
module parity_frame_rx #(
  parameter int unsigned DATA_W = 8
) (
  input logic              clk,
  input logic              rst,
  parity_frame_rx_if.slave bus
);

  localparam int unsigned CW = $clog2(DATA_W) + 1;

`ifdef PARITY_ODD_EN
  localparam logic PAR_P = 1'b1;
`else
  localparam logic PAR_P = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              acc_q, acc_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic              mis_q, mis_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dv_q, dv_d;
  logic              pe_q, pe_d;
  logic              fe_q, fe_d;

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      sr_q    <= '0;
      mis_q   <= 1'b0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sr_q    <= sr_d;
      mis_q   <= mis_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (bus.din_valid && !bus.din) state_d = DATA;
      DATA:   if (bus.din_valid && cnt_q == CW'(DATA_W - 1)) state_d = PARITY;
      PARITY: if (bus.din_valid) state_d = STOP;
      STOP:   if (bus.din_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    sr_d   = sr_q;
    mis_d  = mis_q;
    dout_d = dout_q;
    pe_d   = pe_q;
    fe_d   = fe_q;
    dv_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.din_valid && !bus.din) begin
          cnt_d = '0;
          acc_d = 1'b0;
        end
      end
      DATA: begin
        if (bus.din_valid) begin
          // Decoded write avoids indexing with the wider counter
          for (int unsigned i = 0; i < DATA_W; i++) begin
            if (cnt_q == CW'(i)) sr_d[i] = bus.din;
          end
          acc_d = acc_q ^ bus.din;
          cnt_d = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        if (bus.din_valid) mis_d = acc_q ^ bus.din ^ PAR_P;
      end
      STOP: begin
        if (bus.din_valid) begin
          dout_d = sr_q;
          pe_d   = mis_q;
          fe_d   = ~bus.din;
          dv_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy       = (state_q != IDLE);
    bus.dout       = dout_q;
    bus.dout_valid = dv_q;
    bus.par_err    = pe_q;
    bus.frm_err    = fe_q;
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
module tb_parity_frame_rx;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst;

  parity_frame_rx_if #(.DATA_W(DW)) bus();

  parity_frame_rx #(.DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic          p;
    logic          f;
    int unsigned   cyc;
  } exp_t;

  exp_t exp_q[$];

  logic [DW-1:0] hold_d = '0;
  logic          hold_p = 1'b0;
  logic          hold_f = 1'b0;

  // Reference: count ones in data+parity bit, compare against the configured sense
  function automatic logic model_par_err(logic [DW-1:0] d, logic pb);
    int unsigned ones;
    ones = $countones(d) + int'(pb);
`ifdef PARITY_ODD_EN
    return (ones % 2) == 0;
`else
    return (ones % 2) == 1;
`endif
  endfunction

  task automatic chk(string nm, int act, int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: continuous strobe, 1: one dead cycle before each bit, 2: random gaps
  task automatic send_bit(logic b, int mode, bit push, exp_t e);
    int gaps;
    gaps = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
    repeat (gaps) begin
      bus.din_valid = 1'b0;
      bus.din       = 1'($urandom);
      step();
    end
    if (push) begin
      e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    bus.din_valid = 1'b1;
    bus.din       = b;
    step();
  endtask

  task automatic send_frame(logic [DW-1:0] d, logic pb, logic sb, int mode);
    exp_t e;
    e.d   = d;
    e.p   = model_par_err(d, pb);
    e.f   = ~sb;
    e.cyc = 0;
    send_bit(1'b0, mode, 1'b0, e);
    chk("busy_start", int'(bus.busy), 1);
    for (int i = 0; i < int'(DW); i++) begin
      send_bit(d[i], mode, 1'b0, e);
      chk("busy_data", int'(bus.busy), 1);
    end
    send_bit(pb, mode, 1'b0, e);
    chk("busy_parity", int'(bus.busy), 1);
    send_bit(sb, mode, 1'b1, e);
    chk("idle_after_stop", int'(bus.busy), 0);
    bus.din_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.din_valid = 1'b0;
    bus.din       = 1'b1;
    step();
    hold_d = '0;
    hold_p = 1'b0;
    hold_f = 1'b0;
    rst    = 1'b0;
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_dout_valid", int'(bus.dout_valid), 0);
    chk("rst_par_err", int'(bus.par_err), 0);
    chk("rst_frm_err", int'(bus.frm_err), 0);
    chk("rst_busy", int'(bus.busy), 0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (bus.dout_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: got dout_valid=1 dout=%0h expected no pulse (cycle %0d)",
                 bus.dout, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("dout", int'(bus.dout), int'(e.d));
        chk("par_err", int'(bus.par_err), int'(e.p));
        chk("frm_err", int'(bus.frm_err), int'(e.f));
        chk("latency", int'(cyc), int'(e.cyc));
        hold_d = e.d;
        hold_p = e.p;
        hold_f = e.f;
      end
    end else begin
      chk("hold_dout", int'(bus.dout), int'(hold_d));
      chk("hold_par_err", int'(bus.par_err), int'(hold_p));
      chk("hold_frm_err", int'(bus.frm_err), int'(hold_f));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.din       = 1'b1;
    bus.din_valid = 1'b0;
    step();
    do_reset();

    // Idle-high line must not start a frame
    repeat (5) begin
      bus.din_valid = 1'b1;
      bus.din       = 1'b1;
      step();
      chk("idle_high_busy", int'(bus.busy), 0);
    end
    bus.din_valid = 1'b0;
    step();

    send_frame(8'hA5, 1'b0, 1'b1, 0);
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    step();
    send_frame(8'h01, 1'b1, 1'b1, 1);
    step();

    // Partial frame discarded by reset, then a full frame
    begin
      exp_t dummy;
      dummy = '{d: '0, p: 1'b0, f: 1'b0, cyc: 0};
      send_bit(1'b0, 0, 1'b0, dummy);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 0, 1'b0, dummy);
      chk("busy_before_rst", int'(bus.busy), 1);
    end
    do_reset();
    send_frame(8'hFF, 1'b0, 1'b1, 0);
    step();

    // Back-to-back: second start bit lands in the dout_valid cycle
    send_frame(8'h12, 1'b0, 1'b1, 0);
    send_frame(8'h34, 1'b1, 1'b1, 0);
    step();

    // Randomized frames
    for (int k = 0; k < 30; k++) begin
      logic [DW-1:0] d;
      d = DW'($urandom);
      send_frame(d, 1'($urandom), ($urandom_range(0, 3) != 0), int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_frame_rx.md
PARITY_FRAME_RX -- requirements
Module: parity_frame_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (legal 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port din  input  1  serial line bit, sampled only when din_valid=1.
REQ-005 SHALL have port din_valid  input  1  bit strobe; din ignored when 0.
REQ-006 SHALL have port dout  output  DATA_W  received data word, LSB first on line.
REQ-007 SHALL have port dout_valid  output  1  one-cycle pulse, dout/par_err/frm_err valid.
REQ-008 SHALL have port par_err  output  1  parity mismatch for the frame reported with dout_valid.
REQ-009 SHALL have port frm_err  output  1  stop bit sampled as 0 for the frame reported with dout_valid.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-012 IDLE -> DATA when din_valid=1 and din=0 (start bit); bit counter cleared, parity accumulator cleared.
REQ-013 IDLE with din_valid=1 and din=1 SHALL stay IDLE (line idle high).
REQ-014 In DATA, each din_valid=1 cycle SHALL shift din into bit position cnt of a shift register, XOR din into the accumulator, increment cnt.
REQ-015 DATA -> PARITY on the din_valid cycle that captures bit DATA_W-1; cnt width ceil(log2(DATA_W))+1, no wrap inside a frame.
REQ-016 In PARITY, on din_valid=1, SHALL latch mismatch = acc XOR din XOR P (P=0 even, P=1 odd per REQ-025/026); -> STOP.
REQ-017 In STOP, on din_valid=1, SHALL register dout=shift register, par_err=mismatch, frm_err=~din, pulse dout_valid for exactly one cycle on the next edge; -> IDLE.
REQ-018 Latency: dout_valid asserted the cycle immediately after the clock edge sampling the stop bit.
REQ-019 din_valid=0 in any state SHALL hold state, counter, accumulator and shift register (stall).
REQ-020 dout, par_err, frm_err SHALL hold their last values until the next dout_valid; dout_valid=0 otherwise.
REQ-021 A start bit arriving in the same cycle dout_valid pulses SHALL be accepted (back-to-back frames, no idle bit required).
REQ-022 A frame with frm_err=1 SHALL still present dout and par_err; FSM returns to IDLE regardless.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, cnt=0, acc=0, shift register=0, dout=0, dout_valid=0, par_err=0, frm_err=0, busy=0.
REQ-024 rst asserted mid-frame SHALL discard the partial frame with no dout_valid; rst has priority over din_valid.

Configuration
REQ-025 With macro PARITY_ODD_EN defined, SHALL check odd parity (data bits plus parity bit contain an odd number of ones).
REQ-026 Without PARITY_ODD_EN, SHALL check even parity; no other behaviour differs.

Verification
REQ-027 Even build, din_valid=1 continuous, line 0,(A5 LSB first: 1,0,1,0,0,1,0,1),0,1 -> dout=8'hA5, par_err=0, frm_err=0, one dout_valid pulse 11 cycles after start bit edge... i.e. one cycle after stop bit.
REQ-028 Even build, same frame with parity bit 1 -> dout=8'hA5, par_err=1; odd build with parity bit 1 -> par_err=0.
REQ-029 Frame 8'h3C, even parity 0, stop bit 0 -> dout=8'h3C, frm_err=1, par_err=0; FSM in IDLE next cycle.
REQ-030 Frame 8'h01 with din_valid toggling 1,0,1,0 each cycle -> identical result to continuous strobe, dout_valid once, busy high throughout frame.
REQ-031 rst pulsed after 4th data bit, then full frame 8'hFF parity 0 stop 1 -> only one dout_valid, dout=8'hFF, par_err=0.
REQ-032 Two frames 8'h12 and 8'h34 back-to-back, second start bit in dout_valid cycle -> two pulses, dout=8'h12 then 8'h34, no errors.
